// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared state enumeration and default constants for the fetch
//               sequencer (IRQ support selected by macro FETCH_SEQ_IRQ_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   localparam int          DEFAULT_INC        = 2;
   localparam logic [15:0] DEFAULT_IRQ_VECTOR = 16'h0004;

endpackage
`default_nettype wire

// File: rtl/fetch_next_select.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_select
// Description : Combinational next-PC priority mux; the irq/iret inputs and
//               resume output exist only when FETCH_SEQ_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_select
   import fetch_sequencer_pkg::*;
#(
   parameter int SIZE = 16,
   parameter int INC  = DEFAULT_INC
`ifdef FETCH_SEQ_IRQ_EN
   ,
   parameter logic [SIZE-1:0] IRQ_VECTOR = SIZE'(DEFAULT_IRQ_VECTOR)
`endif
) (
   input  logic [SIZE-1:0] current_address,
   input  logic            branch_taken,
   input  logic [SIZE-1:0] branch_target,
   input  logic            jump,
   input  logic [SIZE-1:0] jump_target,
`ifdef FETCH_SEQ_IRQ_EN
   input  logic            take_irq,
   input  logic            iret,
   input  logic [SIZE-1:0] epc_address,
   output logic [SIZE-1:0] resume_address,
`endif
   output logic [SIZE-1:0] next_address
);

   logic [SIZE-1:0] selected;

   // Everything below the interrupt; this is also what the EPC captures.
   always_comb begin
      selected = current_address + SIZE'(INC);
`ifdef FETCH_SEQ_IRQ_EN
      if (iret)
         selected = epc_address;
      else
`endif
      if (jump)
         selected = jump_target;
      else if (branch_taken)
         selected = branch_target;
   end

`ifdef FETCH_SEQ_IRQ_EN
   assign resume_address = selected;
   assign next_address   = take_irq ? IRQ_VECTOR : selected;
`else
   assign next_address   = selected;
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : IDLE/FETCH/EXEC/HALT instruction fetch sequencer driving the
//               PC load strobe; interrupt support under FETCH_SEQ_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int SIZE    = 16,
   parameter int INSTR_W = 16,
   parameter int INC     = DEFAULT_INC
`ifdef FETCH_SEQ_IRQ_EN
   ,
   parameter logic [SIZE-1:0] IRQ_VECTOR = SIZE'(DEFAULT_IRQ_VECTOR)
`endif
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [SIZE-1:0]    currentAddress,
   output logic               pcWrite,
   output logic [SIZE-1:0]    nextAddress,
   output logic               imemReq,
   output logic [SIZE-1:0]    imemAddr,
   input  logic               imemReady,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instr,
   output logic               instrValid,
   input  logic               done,
   input  logic               stall,
   input  logic               branchTaken,
   input  logic [SIZE-1:0]    branchTarget,
   input  logic               jump,
   input  logic [SIZE-1:0]    jumpTarget,
   input  logic               halt,
`ifdef FETCH_SEQ_IRQ_EN
   input  logic               irq,
   input  logic               iret,
   output logic               irqAck,
   output logic [SIZE-1:0]    epcAddress,
`endif
   output logic               halted
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic         complete;

   // The only cycle in which the PC is loaded and redirects are honoured.
   assign complete = (state == EXEC) && done && !stall;
   assign imemAddr = currentAddress;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = FETCH;
         FETCH:   if (imemReady) state_next = EXEC;
         EXEC:    if (complete) state_next = halt ? HALT : FETCH;
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      imemReq    = 1'b0;
      instrValid = 1'b0;
      pcWrite    = 1'b0;
      halted     = 1'b0;
      case (state)
         FETCH:   imemReq = 1'b1;
         EXEC: begin
            instrValid = 1'b1;
            pcWrite    = complete;
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         instr <= '0;
      else if (state == FETCH && imemReady)
         instr <= imemData;
   end

`ifdef FETCH_SEQ_IRQ_EN
   logic            irq_mask;
   logic            take_irq;
   logic [SIZE-1:0] resume_address;

   assign take_irq = complete && irq && !irq_mask;
   assign irqAck   = take_irq;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_mask   <= 1'b0;
         epcAddress <= '0;
      end else if (take_irq) begin
         irq_mask   <= 1'b1;
         epcAddress <= resume_address;
      end else if (complete && iret) begin
         irq_mask   <= 1'b0;
      end
   end
`endif

   fetch_next_select #(
      .SIZE (SIZE),
      .INC  (INC)
`ifdef FETCH_SEQ_IRQ_EN
      ,
      .IRQ_VECTOR (IRQ_VECTOR)
`endif
   ) u_next_select (
      .current_address (currentAddress),
      .branch_taken    (branchTaken),
      .branch_target   (branchTarget),
      .jump            (jump),
      .jump_target     (jumpTarget),
`ifdef FETCH_SEQ_IRQ_EN
      .take_irq        (take_irq),
      .iret            (iret),
      .epc_address     (epcAddress),
      .resume_address  (resume_address),
`endif
      .next_address    (nextAddress)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer (IRQ scenarios built
//               when FETCH_SEQ_IRQ_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] currentAddress = '0;
   logic        pcWrite;
   logic [15:0] nextAddress;
   logic        imemReq;
   logic [15:0] imemAddr;
   logic        imemReady = 1'b0;
   logic [15:0] imemData = '0;
   logic [15:0] instr;
   logic        instrValid;
   logic        done = 1'b0, stall = 1'b0;
   logic        branchTaken = 1'b0, jump = 1'b0, halt = 1'b0;
   logic [15:0] branchTarget = '0, jumpTarget = '0;
   logic        halted;
`ifdef FETCH_SEQ_IRQ_EN
   logic        irq = 1'b0, iret = 1'b0;
   logic        irqAck;
   logic [15:0] epcAddress;
   logic        want_irq, want_iret, m_mask;
   logic [15:0] m_epc;
`endif

   int          checks = 0;
   int          passed = 0;
   logic        want_jump, want_br, want_halt;
   logic [15:0] want_jt, want_bt;

   always #5 clock = ~clock;

   fetch_sequencer #(.SIZE(16), .INSTR_W(16), .INC(2)) dut (
      .clock(clock), .reset(reset), .currentAddress(currentAddress),
      .pcWrite(pcWrite), .nextAddress(nextAddress), .imemReq(imemReq),
      .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
      .instr(instr), .instrValid(instrValid), .done(done), .stall(stall),
      .branchTaken(branchTaken), .branchTarget(branchTarget), .jump(jump),
      .jumpTarget(jumpTarget), .halt(halt),
`ifdef FETCH_SEQ_IRQ_EN
      .irq(irq), .iret(iret), .irqAck(irqAck), .epcAddress(epcAddress),
`endif
      .halted(halted)
   );

   task automatic clear_want();
      want_jump = 0; want_br = 0; want_halt = 0; want_jt = '0; want_bt = '0;
`ifdef FETCH_SEQ_IRQ_EN
      want_irq = 0; want_iret = 0;
`endif
   endtask

   // Random values on redirect inputs in cycles where they must be ignored.
   task automatic noise();
      jump = 1'($urandom_range(1, 0)); jumpTarget = 16'($urandom);
      branchTaken = 1'($urandom_range(1, 0)); branchTarget = 16'($urandom);
      halt = 1'($urandom_range(1, 0));
`ifdef FETCH_SEQ_IRQ_EN
      irq = 1'($urandom_range(1, 0)); iret = 1'($urandom_range(1, 0));
`endif
   endtask

   // One instruction from the first FETCH cycle to its completion cycle.
   task automatic run_instr(input logic [15:0] addr, input int delay, input int waits,
                            input int stalls, input logic [15:0] data);
      logic [15:0] exp_next, resume;
      logic        last, take;
      take = 0;
      for (int i = 0; i <= delay; i++) begin
         @(negedge clock);
         currentAddress = addr;
         imemReady = (i == delay);
         imemData = (i == delay) ? data : 16'($urandom);
         done = 1'($urandom_range(1, 0)); stall = 1'($urandom_range(1, 0));
         noise();
         #1;
         checks++;
         if (imemReq !== 1'b1 || imemAddr !== addr || instrValid !== 1'b0 || pcWrite !== 1'b0 || halted !== 1'b0)
            $display("FAIL fetch_phase cyc%0d: imemReq=%b imemAddr=%h instrValid=%b pcWrite=%b halted=%b, want 1 %h 0 0 0",
                     i, imemReq, imemAddr, instrValid, pcWrite, halted, addr);
         else passed++;
`ifdef FETCH_SEQ_IRQ_EN
         checks++;
         if (irqAck !== 1'b0 || epcAddress !== m_epc)
            $display("FAIL fetch_irq_state: irqAck=%b epc=%h, want 0 %h", irqAck, epcAddress, m_epc);
         else passed++;
`endif
      end
      for (int i = 0; i <= waits + stalls; i++) begin
         @(negedge clock);
         last = (i == waits + stalls);
         imemReady = 1'($urandom_range(1, 0)); imemData = 16'($urandom);
         if (last) begin
            done = 1; stall = 0;
            jump = want_jump; jumpTarget = want_jt; branchTaken = want_br; branchTarget = want_bt;
            halt = want_halt;
`ifdef FETCH_SEQ_IRQ_EN
            irq = want_irq; iret = want_iret;
`endif
         end else begin
            done = (i >= waits); stall = (i >= waits) ? 1'b1 : 1'($urandom_range(1, 0));
            noise();
         end
         #1;
         checks++;
         if (instrValid !== 1'b1 || instr !== data || imemReq !== 1'b0 || halted !== 1'b0 || pcWrite !== last)
            $display("FAIL exec_phase cyc%0d: instrValid=%b instr=%h imemReq=%b halted=%b pcWrite=%b, want 1 %h 0 0 %b",
                     i, instrValid, instr, imemReq, halted, pcWrite, data, last);
         else passed++;
         if (last) begin
            if (want_jump) resume = want_jt;
            else if (want_br) resume = want_bt;
            else resume = addr + 16'd2;
            exp_next = resume;
`ifdef FETCH_SEQ_IRQ_EN
            if (want_iret && !(want_irq && !m_mask)) exp_next = m_epc;
            if (want_iret) resume = m_epc;
            take = want_irq && !m_mask;
            if (take) exp_next = 16'h0004;
`endif
            checks++;
            if (nextAddress !== exp_next)
               $display("FAIL next_address @%h: got %h, want %h", addr, nextAddress, exp_next);
            else passed++;
         end
`ifdef FETCH_SEQ_IRQ_EN
         checks++;
         if (irqAck !== (last && take) || epcAddress !== m_epc)
            $display("FAIL exec_irq_state: irqAck=%b epc=%h, want %b %h", irqAck, epcAddress, last && take, m_epc);
         else passed++;
         if (last && take) begin m_mask = 1; m_epc = resume; end
         else if (last && want_iret) m_mask = 0;
`endif
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (pcWrite !== 0 || imemReq !== 0 || instrValid !== 0 || halted !== 0 || instr !== 16'h0)
         $display("FAIL %s: pcWrite=%b imemReq=%b instrValid=%b halted=%b instr=%h, want all 0",
                  name, pcWrite, imemReq, instrValid, halted, instr);
      else passed++;
`ifdef FETCH_SEQ_IRQ_EN
      checks++;
      if (irqAck !== 0 || epcAddress !== 16'h0)
         $display("FAIL %s_irq: irqAck=%b epc=%h, want 0 0000", name, irqAck, epcAddress);
      else passed++;
      m_mask = 0; m_epc = '0;
`endif
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1;
      #1;
      checks++;
      if (imemReq !== 0 || pcWrite !== 0 || instrValid !== 0)
         $display("FAIL idle_cycle: imemReq=%b pcWrite=%b instrValid=%b, want 0 0 0", imemReq, pcWrite, instrValid);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 0;
      #3;
      check_all_zero("reset_state");
      release_reset();
   endtask

   task automatic test_basic();
      clear_want();
      run_instr(16'h0000, 2, 0, 0, 16'hA5C3);
   endtask

   task automatic test_priority();
      clear_want();
      want_jump = 1; want_jt = 16'h0080; want_br = 1; want_bt = 16'h0040;
      run_instr(16'h0002, 0, 1, 0, 16'h1234);
      clear_want();
      want_br = 1; want_bt = 16'h0040;
      run_instr(16'h0080, 1, 0, 0, 16'h4321);
   endtask

   task automatic test_wrap();
      clear_want();
      run_instr(16'hFFFE, 0, 0, 0, 16'h0F0F);
   endtask

   task automatic test_stall();
      clear_want();
      run_instr(16'h0000, 1, 0, 3, 16'h5A5A);
      run_instr(16'h0002, 0, 0, 0, 16'h6B6B);
   endtask

`ifdef FETCH_SEQ_IRQ_EN
   task automatic test_irq();
      clear_want(); want_irq = 1;
      run_instr(16'h0010, 0, 0, 0, 16'h7777);
      @(posedge clock); #1;
      checks++;
      if (epcAddress !== 16'h0012) $display("FAIL irq_epc: got %h, want 0012", epcAddress);
      else passed++;
      run_instr(16'h0004, 1, 0, 0, 16'h8888);
      clear_want(); want_iret = 1;
      run_instr(16'h0006, 0, 0, 0, 16'h9999);
      clear_want(); want_irq = 1;
      run_instr(16'h0012, 0, 0, 1, 16'hAAAA);
      clear_want(); want_iret = 1;
      run_instr(16'h0004, 0, 0, 0, 16'hBBBB);
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         clear_want();
         want_jump = ($urandom_range(3, 0) == 0); want_jt = 16'($urandom);
         want_br = ($urandom_range(2, 0) == 0); want_bt = 16'($urandom);
`ifdef FETCH_SEQ_IRQ_EN
         want_irq = ($urandom_range(3, 0) == 0); want_iret = ($urandom_range(4, 0) == 0);
`endif
         run_instr(16'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                   int'($urandom_range(3, 0)), 16'($urandom));
      end
   endtask

   task automatic test_halt();
      clear_want(); want_halt = 1;
      run_instr(16'h0100, 0, 0, 0, 16'hC0DE);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         done = 1; stall = 0; imemReady = 1; noise();
         #1;
         checks++;
         if (halted !== 1 || imemReq !== 0 || pcWrite !== 0 || instrValid !== 0)
            $display("FAIL halt_state: halted=%b imemReq=%b pcWrite=%b instrValid=%b, want 1 0 0 0",
                     halted, imemReq, pcWrite, instrValid);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_op();
      reset = 0; #1;
      check_all_zero("reset_from_halt");
      release_reset();
      @(negedge clock);
      imemReady = 1; imemData = 16'hBEEF; done = 1; stall = 0; noise();
      #1; reset = 0; #1;
      check_all_zero("reset_mid_fetch");
      @(posedge clock); #1;
      check_all_zero("reset_held_edge");
      release_reset();
      clear_want();
      run_instr(16'h0200, 0, 1, 0, 16'hFACE);
      #1; reset = 0; #1;
      check_all_zero("reset_mid_exec");
      release_reset();
      clear_want();
      run_instr(16'h0300, 1, 0, 0, 16'h0BAD);
   endtask

   initial begin
      clear_want();
`ifdef FETCH_SEQ_IRQ_EN
      m_mask = 0; m_epc = '0;
`endif
      test_reset();
      test_basic();
      test_priority();
      test_wrap();
      test_stall();
`ifdef FETCH_SEQ_IRQ_EN
      test_irq();
`endif
      test_random();
      test_halt();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SIZE, 16, address width in bits.
REQ-002 INSTR_W, 16, instruction width in bits.
REQ-003 INC, 2, sequential address increment.
REQ-004 IRQ_VECTOR, 'h0004, interrupt target address (used only with FETCH_SEQ_IRQ_EN).
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 currentAddress  input  SIZE  present program counter value.
REQ-008 pcWrite  output  1  one-cycle strobe that loads nextAddress into the program counter.
REQ-009 nextAddress  output  SIZE  address to load when pcWrite=1.
REQ-010 imemReq  output  1  instruction fetch request.
REQ-011 imemAddr  output  SIZE  fetch address; equals currentAddress.
REQ-012 imemReady  input  1  fetch complete; imemData valid this cycle.
REQ-013 imemData  input  INSTR_W  fetched instruction.
REQ-014 instr  output  INSTR_W  registered instruction for the datapath.
REQ-015 instrValid  output  1  instr is held for execution.
REQ-016 done  input  1  datapath finished the current instruction.
REQ-017 stall  input  1  hold the sequencer; overrides done.
REQ-018 branchTaken  input  1  plus branchTarget  input  SIZE: conditional redirect.
REQ-019 jump  input  1  plus jumpTarget  input  SIZE: unconditional redirect.
REQ-020 halt  input  1  stop after the current instruction.
REQ-021 halted  output  1  sequencer is stopped.
REQ-022 irq  input  1, iret  input  1, irqAck  output  1, epcAddress  output  SIZE: present only with FETCH_SEQ_IRQ_EN.

Function
REQ-023 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT.
REQ-024 IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-025 FETCH: imemReq=1. On imemReady=1 the block SHALL latch imemData into instr and move to EXEC; otherwise it stays in FETCH with no timeout.
REQ-026 EXEC: instrValid=1. When done=1 and stall=0, the block SHALL pulse pcWrite for exactly that cycle and go to FETCH, or go to HALT if halt=1.
REQ-027 In EXEC, stall=1 SHALL suppress pcWrite, and the block SHALL stay in EXEC with instr unchanged.
REQ-028 nextAddress priority: irq (when enabled) > iret > jump > branchTaken > sequential.
REQ-029 Sequential nextAddress = currentAddress + INC, truncated to SIZE bits, so it wraps modulo 2^SIZE.
REQ-030 nextAddress SHALL be combinational and valid whenever pcWrite=1.
REQ-031 Redirect inputs SHALL be ignored outside the EXEC-completion cycle.
REQ-032 HALT: halted=1, no requests and no pcWrite; the only exit is reset.
REQ-033 Fetch latency: imemReq asserts on the first cycle in FETCH; instrValid asserts on the cycle after imemReady is sampled.

Reset
REQ-034 While reset=0, outputs SHALL be as follows, independent of clock: state=IDLE; pcWrite, imemReq, instrValid, halted, irqAck=0; instr=0; epcAddress=0; interrupt mask cleared.
REQ-035 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the operation with no pcWrite issued.

Configuration
REQ-036 The macro FETCH_SEQ_IRQ_EN SHALL control interrupt support.
REQ-037 With FETCH_SEQ_IRQ_EN defined:
- irq=1 at the EXEC completion cycle, with mask=0, SHALL select IRQ_VECTOR.
- epcAddress SHALL be loaded with the address that would otherwise have been selected.
- irqAck SHALL pulse for 1 cycle and mask SHALL be set.
- iret=1 at completion SHALL select epcAddress and clear mask.
- irq while mask=1 SHALL be ignored.
REQ-038 Without FETCH_SEQ_IRQ_EN: the irq, iret, irqAck and epcAddress ports and logic SHALL be absent, and priority starts at jump.

Structure
REQ-039 The shared package SHALL hold the state enumeration (IDLE/FETCH/EXEC/HALT) and the default INC and IRQ_VECTOR constants.
REQ-040 The next-address priority mux SHALL be a combinational sub-module, fetch_next_select.

Verification
REQ-041 Reset release with currentAddress=0x0000, imemReady after 2 cycles, done with no redirect -> imemReq for 3 cycles; nextAddress=0x0002 with one pcWrite pulse.
REQ-042 At completion, jump=1 (0x0080) and branchTaken=1 (0x0040) together -> nextAddress=0x0080.
REQ-043 currentAddress=0xFFFE, sequential completion -> nextAddress=0x0000.
REQ-044 done=1 with stall=1 for 3 cycles -> no pcWrite until stall=0, then a single pulse.
REQ-045 (IRQ_EN) At 0x0010, irq at completion -> nextAddress=0x0004, epcAddress=0x0012, one irqAck pulse; a repeat irq is ignored; iret -> nextAddress=0x0012.
REQ-046 Reset dropped mid-FETCH -> all outputs 0 immediately; halt at completion -> halted=1, no further imemReq.
